multi_axis_stepper: RTL and testbench

Parametrised N-axis unipolar stepper controller for the claw machine, generalising the single-axis claw movement block. It takes per-axis forward/backward requests and limit-switch (stopper) inputs from the PMOD pins, runs a shared step-rate prescaler, and drives 4 coil outputs per axis. It adds features the single-axis block lacks: position counters, a travel ceiling, a homing sequence and idle coil release. It sits in the wrapper between the JA/JC input pins and the JA/JB/JD motor-driver pins, and its position outputs are available for processor register writes.

---
 rtl/multi_axis_stepper.sv | 235 +++++++++++++++++++++++
 tb/tb_multi_axis_stepper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_axis_stepper.sv
`timescale 1ns/1ps
// ============================================================================
// multi_axis_stepper
// ----------------------------------------------------------------------------
// Purpose : N-axis unipolar stepper controller for the claw machine. Takes
//           per-axis forward/backward requests and home limit switches from
//           the PMOD pins. Steps every axis on a shared prescaled tick. Keeps
//           a position counter per axis with a forward travel ceiling. Runs a
//           homing sequence that drives every axis onto its limit switch.
//           Releases the coils once an axis has been idle for HOLD_TICKS
//           ticks.
//
// Build option:
//   HALF_STEP_EN : when defined, uses the 8-entry half-step sequence with a
//                  3-bit phase index (pos and POS_MAX count half-steps).
//                  When undefined, uses the 4-entry full-step sequence with
//                  a 2-bit phase index.
//
// Ports:
//   CLK100MHZ  in   system clock
//   reset      in   synchronous, active-high reset
//   fwd        in   [NUM_AXES]  forward request per axis (async pin, level)
//   bwd        in   [NUM_AXES]  backward / toward-home request (async pin)
//   limit      in   [NUM_AXES]  home limit switch, active-high (async pin)
//   home       in   homing request, acts on its rising edge (async pin)
//   coils      out  [4*NUM_AXES] axis a drives bits [4a+3:4a] =
//                   {coil4,coil3,coil2,coil1}
//   pos        out  [POS_WIDTH*NUM_AXES] axis a position at [POS_WIDTH*a +:]
//   moving     out  [NUM_AXES]  axis a has a qualified step direction
//   homing     out  homing sequence in progress
//   homed      out  [NUM_AXES]  axis a has been zeroed since reset
// ============================================================================
module multi_axis_stepper #(
    parameter int NUM_AXES   = 3,
    parameter int STEP_DIV   = 100000,
    parameter int POS_WIDTH  = 16,
    parameter int POS_MAX    = 4095,
    parameter int HOLD_TICKS = 8
) (
    input  logic                          CLK100MHZ,
    input  logic                          reset,
    input  logic [NUM_AXES-1:0]           fwd,
    input  logic [NUM_AXES-1:0]           bwd,
    input  logic [NUM_AXES-1:0]           limit,
    input  logic                          home,
    output logic [4*NUM_AXES-1:0]         coils,
    output logic [POS_WIDTH*NUM_AXES-1:0] pos,
    output logic [NUM_AXES-1:0]           moving,
    output logic                          homing,
    output logic [NUM_AXES-1:0]           homed
);

`ifdef HALF_STEP_EN
    localparam int PH_W = 3;
`else
    localparam int PH_W = 2;
`endif
    localparam int CNT_W  = $clog2(STEP_DIV);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOME = 1'b1;

    // The phase index width equals log2 of the sequence length. Plain
    // wrap-around arithmetic on the index therefore gives the modulo stepping.
    function automatic logic [3:0] phase_pattern(input logic [PH_W-1:0] idx);
`ifdef HALF_STEP_EN
        case (idx)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0011;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b1100;
            3'd6:    return 4'b1000;
            default: return 4'b1001;
        endcase
`else
        case (idx)
            2'd0:    return 4'b0011;
            2'd1:    return 4'b0110;
            2'd2:    return 4'b1100;
            default: return 4'b1001;
        endcase
`endif
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers (two flops each) plus a delayed copy of home
    // for rising-edge detection.
    // ------------------------------------------------------------------
    logic [NUM_AXES-1:0] fwd_m, fwd_s, bwd_m, bwd_s, lim_m, lim_s;
    logic                home_m, home_s, home_d;

    // NOTE: every clocked block uses non-blocking assignments. The second
    // flop must sample the first flop's old value, not the value it is
    // being given on this same edge.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            fwd_m  <= '0;
            fwd_s  <= '0;
            bwd_m  <= '0;
            bwd_s  <= '0;
            lim_m  <= '0;
            lim_s  <= '0;
            home_m <= 1'b0;
            home_s <= 1'b0;
            home_d <= 1'b0;
        end else begin
            fwd_m  <= fwd;
            fwd_s  <= fwd_m;
            bwd_m  <= bwd;
            bwd_s  <= bwd_m;
            lim_m  <= limit;
            lim_s  <= lim_m;
            home_m <= home;
            home_s <= home_m;
            home_d <= home_s;
        end
    end

    logic home_rise;
    assign home_rise = home_s & ~home_d;

    // ------------------------------------------------------------------
    // Shared step-rate prescaler
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == CNT_W'(STEP_DIV - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // Homing FSM. A home edge seen while already homing is ignored.
    // ------------------------------------------------------------------
    logic [0:0] state;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (home_rise) state <= ST_HOME;
                default: if (&homed)    state <= ST_IDLE;
            endcase
        end
    end

    assign homing = (state == ST_HOME);

    // ------------------------------------------------------------------
    // Per-axis datapath
    // ------------------------------------------------------------------
    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        logic [POS_WIDTH-1:0] pos_r, pos_nxt;
        logic [PH_W-1:0]      phase, phase_nxt;
        logic [HOLD_W-1:0]    hold, hold_nxt;
        logic [3:0]           coil_r;
        logic                 homed_r;
        logic                 step_up, step_dn, zero_now;

        // NOTE: every signal gets a default at the top of the block. Any
        // path that leaves one unassigned would infer a latch.
        always_comb begin
            step_up   = 1'b0;
            step_dn   = 1'b0;
            zero_now  = 1'b0;
            pos_nxt   = pos_r;
            phase_nxt = phase;
            hold_nxt  = hold;

            if (state == ST_HOME) begin
                // Manual requests are ignored. An unhomed axis drives toward
                // its switch. Once the switch is seen, the axis is zeroed on
                // the next tick and then holds.
                if (!homed_r) begin
                    if (lim_s[a]) zero_now = 1'b1;
                    else          step_dn  = 1'b1;
                end
            end else begin
                step_up = fwd_s[a] & ~bwd_s[a] & (pos_r != POS_WIDTH'(POS_MAX));
                step_dn = bwd_s[a] & ~fwd_s[a] & ~lim_s[a];
            end

            if (tick) begin
                if (step_up) begin
                    phase_nxt = phase + PH_W'(1);
                    pos_nxt   = pos_r + POS_WIDTH'(1);
                    hold_nxt  = HOLD_W'(HOLD_TICKS);
                end else if (step_dn) begin
                    phase_nxt = phase - PH_W'(1);
                    pos_nxt   = pos_r - POS_WIDTH'(1);
                    hold_nxt  = HOLD_W'(HOLD_TICKS);
                end else begin
                    if (hold != '0) hold_nxt = hold - HOLD_W'(1);
                    if (zero_now)   pos_nxt  = '0;
                end
            end
        end

        // NOTE: all state, including the position counters, is cleared by
        // reset. After a reset the axis reads position 0 and counts as
        // unhomed until a new homing run.
        always_ff @(posedge CLK100MHZ) begin
            if (reset) begin
                pos_r   <= '0;
                phase   <= '0;
                hold    <= '0;
                coil_r  <= 4'b0000;
                homed_r <= 1'b0;
            end else begin
                pos_r  <= pos_nxt;
                phase  <= phase_nxt;
                hold   <= hold_nxt;
                // Coils are registered from the next-state values. They
                // therefore change on the same edge as pos.
                coil_r <= (hold_nxt != '0) ? phase_pattern(phase_nxt) : 4'b0000;
                if (state == ST_IDLE && home_rise) homed_r <= 1'b0;
                else if (tick && zero_now)         homed_r <= 1'b1;
            end
        end

        assign coils[4*a +: 4]                 = coil_r;
        assign pos[POS_WIDTH*a +: POS_WIDTH]   = pos_r;
        assign moving[a]                       = step_up | step_dn;
        assign homed[a]                        = homed_r;
    end

endmodule

// File: tb/tb_multi_axis_stepper.sv
`timescale 1ns/1ps
// ============================================================================
// tb_multi_axis_stepper
// ----------------------------------------------------------------------------
// Directed bench for multi_axis_stepper with STEP_DIV=4, NUM_AXES=3,
// HOLD_TICKS=2. The default build tests full-step with POS_MAX=5. With
// HALF_STEP_EN defined, it tests the half-step sequence with POS_MAX=20.
// A local copy of the prescaler count lets the stimulus line up with tick
// edges. Inputs change only just after a tick edge. A new input is therefore
// fully synchronised by the following tick.
// ============================================================================
module tb_multi_axis_stepper;

    localparam int NA = 3;
    localparam int SD = 4;
    localparam int PW = 16;
    localparam int HT = 2;
`ifdef HALF_STEP_EN
    localparam int PM = 20;
`else
    localparam int PM = 5;
`endif

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [NA-1:0]     fwd   = '0;
    logic [NA-1:0]     bwd   = '0;
    logic [NA-1:0]     limit = '0;
    logic              home  = 1'b0;
    logic [4*NA-1:0]   coils;
    logic [PW*NA-1:0]  pos;
    logic [NA-1:0]     moving;
    logic              homing;
    logic [NA-1:0]     homed;

    int checks   = 0;
    int failures = 0;
    int m_cnt    = 0;

`ifdef HALF_STEP_EN
    logic [3:0] hs_exp [8] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100,
                               4'b1100, 4'b1000, 4'b1001, 4'b0001};
`else
    logic [3:0] fs_exp [5] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0110};
    int         h_p0   [6] = '{2, 1, 0, 0, 0, 0};
    int         h_p1   [6] = '{4, 3, 2, 1, 0, 0};
    logic [2:0] h_hd   [6] = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b101, 3'b111};
`endif

    always #5 clk = ~clk;

    multi_axis_stepper #(
        .NUM_AXES  (NA),
        .STEP_DIV  (SD),
        .POS_WIDTH (PW),
        .POS_MAX   (PM),
        .HOLD_TICKS(HT)
    ) dut (
        .CLK100MHZ(clk),
        .reset    (reset),
        .fwd      (fwd),
        .bwd      (bwd),
        .limit    (limit),
        .home     (home),
        .coils    (coils),
        .pos      (pos),
        .moving   (moving),
        .homing   (homing),
        .homed    (homed)
    );

    // Independent model of the prescaler phase.
    always @(posedge clk) begin
        if (reset) m_cnt <= 0;
        else       m_cnt <= (m_cnt == SD - 1) ? 0 : m_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pos_of(input int a);
        return 64'(pos[PW*a +: PW]);
    endfunction

    function automatic logic [63:0] coil_of(input int a);
        return 64'(coils[4*a +: 4]);
    endfunction

    // Called #1 after an edge. Returns #1 after the next tick edge.
    task automatic wait_tick();
        while (m_cnt != SD - 1) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_coils"},  64'(coils),  64'd0);
        check({tag, "_pos"},    64'(pos),    64'd0);
        check({tag, "_moving"}, 64'(moving), 64'd0);
        check({tag, "_homing"}, 64'(homing), 64'd0);
        check({tag, "_homed"},  64'(homed),  64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

`ifdef HALF_STEP_EN
        // Half-step forward through all 8 patterns.
        fwd[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_tick();
            check($sformatf("hs_coil_%0d", k), coil_of(0), 64'(hs_exp[k-1]));
            check($sformatf("hs_pos_%0d", k),  pos_of(0),  64'(k));
        end
        fwd[0] = 1'b0;
`else
        // Manual forward on axis 0 up to the ceiling.
        fwd[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            check($sformatf("fwd_pos_%0d", k),  pos_of(0),  64'(k));
            check($sformatf("fwd_coil_%0d", k), coil_of(0), 64'(fs_exp[k-1]));
            check($sformatf("fwd_mov_%0d", k),  64'(moving[0]), 64'(k < 5));
        end
        fwd[0] = 1'b0;
        wait_tick();
        check("ceiling_pos",  pos_of(0),  64'd5);
        check("ceiling_hold", coil_of(0), 64'b0110);

        // Limit blocks the backward request. Axis 0 coils release.
        bwd[1]   = 1'b1;
        limit[1] = 1'b1;
        wait_tick();
        check("lim_moving", 64'(moving[1]), 64'd0);
        check("lim_pos",    pos_of(1),      64'd0);
        check("lim_coil",   coil_of(1),     64'd0);
        check("release0",   coil_of(0),     64'd0);

        // A one-tick forward pulse, then idle hold and release.
        bwd[1] = 1'b0;
        fwd[1] = 1'b1;
        wait_tick();
        check("pulse_pos",  pos_of(1),  64'd1);
        check("pulse_coil", coil_of(1), 64'b0110);
        fwd[1] = 1'b0;
        wait_tick();
        check("hold_coil",  coil_of(1), 64'b0110);
        wait_tick();
        check("rel_coil",   coil_of(1), 64'd0);
        check("rel_pos",    pos_of(1),  64'd1);

        // Conflicting requests on axis 2.
        fwd[2] = 1'b1;
        bwd[2] = 1'b1;
        wait_tick();
        check("conf_pos",    pos_of(2),      64'd0);
        check("conf_moving", 64'(moving[2]), 64'd0);
        check("conf_coil",   coil_of(2),     64'd0);

        // Preload positions 3/5/0.
        fwd[2]   = 1'b0;
        bwd[2]   = 1'b0;
        limit[1] = 1'b0;
        fwd[1]   = 1'b1;
        bwd[0]   = 1'b1;
        wait_tick();
        wait_tick();
        check("pre_pos0",  pos_of(0),  64'd3);
        check("pre_coil0", coil_of(0), 64'b1001);
        bwd[0] = 1'b0;
        wait_tick();
        wait_tick();
        check("pre_pos1",  pos_of(1),  64'd5);
        check("pre_coil1", coil_of(1), 64'b0110);
        check("pre_pos2",  pos_of(2),  64'd0);

        // Homing. A forward request on axis 0 must be ignored.
        fwd[1] = 1'b0;
        limit  = 3'b100;
        home   = 1'b1;
        fwd[0] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            wait_tick();
            home = 1'b0;
            check($sformatf("home_p0_%0d", t), pos_of(0),  64'(h_p0[t]));
            check($sformatf("home_p1_%0d", t), pos_of(1),  64'(h_p1[t]));
            check($sformatf("home_p2_%0d", t), pos_of(2),  64'd0);
            check($sformatf("home_hd_%0d", t), 64'(homed),  64'(h_hd[t]));
            check($sformatf("home_st_%0d", t), 64'(homing), 64'd1);
            if (t == 0) check("home_moving", 64'(moving), 64'b011);
            limit[0] = (h_p0[t] == 0);
            limit[1] = (h_p1[t] == 0);
        end
        @(posedge clk); #1;
        check("home_done", 64'(homing), 64'd0);
        limit[0] = 1'b0;

        // Manual moves resume. Axis 0 goes forward two steps.
        wait_tick();
        wait_tick();
        check("post_pos0",  pos_of(0),  64'd2);
        check("post_coil0", coil_of(0), 64'b1100);

        // Start homing again, then reset after the first homing tick.
        fwd[0] = 1'b0;
        home   = 1'b1;
        wait_tick();
        check("h2_homing", 64'(homing), 64'd1);
        check("h2_pos0",   pos_of(0),   64'd1);
        check("h2_homed",  64'(homed),  64'b110);
        check("h2_coil0",  coil_of(0),  64'b0110);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        home  = 1'b0;
        check_all_zero("midreset");
        wait_tick();
        check("after_pos",    64'(pos),    64'd0);
        check("after_coils",  64'(coils),  64'd0);
        check("after_homing", 64'(homing), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
